// File: rtl/dsum_mul_arbiter.sv
// dsum_mul_arbiter: round-robin sharing of one pipelined signed multiplier among N_REQ requesters
//   clk, reset (async, active-low)       clock and reset
//   req_valid/req_ready/req_a/req_b      per-requester operand handshake, packed by requester index
//   mul_ce/mul_din0/mul_din1/mul_dout    external multiplier (registered inputs + registered product, ce-gated)
//   res_valid/res_ready/res_id/res_data  single result port with backpressure; res_data is mul_dout
//   stat_issued/stat_stall               issue and stall counters, present only with DSUM_MUL_ARB_STATS_EN
module dsum_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 63,
  parameter int B_W     = 11,
  parameter int P_W     = 73,
  parameter int MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*A_W-1:0] req_a,
  input  logic [N_REQ*B_W-1:0] req_b,
  output logic               mul_ce,
  output logic [A_W-1:0]     mul_din0,
  output logic [B_W-1:0]     mul_din1,
  input  logic [P_W-1:0]     mul_dout,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ID_W-1:0]    res_id,
`ifdef DSUM_MUL_ARB_STATS_EN
  output logic [31:0]        stat_issued,
  output logic [31:0]        stat_stall,
`endif
  output logic [P_W-1:0]     res_data
);
  logic [MUL_LAT-1:0] r_vld;
  logic [ID_W-1:0]    r_tag [MUL_LAT];
  logic [ID_W-1:0]    r_ptr;
  logic [N_REQ-1:0]   w_rot;
  logic [ID_W-1:0]    w_off;
  logic [ID_W:0]      w_sum;
  logic [ID_W-1:0]    w_g;
  logic               w_issue;
  assign res_valid = r_vld[MUL_LAT-1];
  assign res_id    = r_tag[MUL_LAT-1];
  assign res_data  = mul_dout;
  assign mul_ce    = !res_valid | res_ready;
  assign w_issue   = mul_ce & |req_valid;
  assign req_ready = w_issue ? (N_REQ'(1) << w_g) : '0;
  assign mul_din0  = req_a[w_g*A_W +: A_W];
  assign mul_din1  = req_b[w_g*B_W +: B_W];
  // Rotate so the pointer sits at bit 0, find the first requester, then rotate the offset back.
  always_comb begin
    w_rot = N_REQ'({req_valid, req_valid} >> r_ptr);
    w_off = '0;
    for (int k = N_REQ-1; k >= 0; k--) if (w_rot[k]) w_off = ID_W'(k);
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    w_g   = (w_sum >= (ID_W+1)'(N_REQ)) ? ID_W'(w_sum - (ID_W+1)'(N_REQ)) : w_sum[ID_W-1:0];
  end
  // Shadow pipeline moves in lockstep with the multiplier registers, so it shares the ce gate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
      r_ptr <= '0;
      for (int i = 0; i < MUL_LAT; i++) r_tag[i] <= '0;
    end else if (mul_ce) begin
      r_vld[0] <= w_issue;
      r_tag[0] <= w_g;
      for (int i = 1; i < MUL_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
      if (w_issue) r_ptr <= (w_g == ID_W'(N_REQ-1)) ? '0 : w_g + 1'b1;
    end
  end
`ifdef DSUM_MUL_ARB_STATS_EN
  logic [31:0] r_stat_issued;
  logic [31:0] r_stat_stall;
  assign stat_issued = r_stat_issued;
  assign stat_stall  = r_stat_stall;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_issued <= '0;
      r_stat_stall  <= '0;
    end else begin
      r_stat_issued <= r_stat_issued + 32'(w_issue);
      r_stat_stall  <= r_stat_stall + 32'(!mul_ce);
    end
  end
`endif
endmodule

// File: tb/tb_dsum_mul_arbiter.sv
// tb_dsum_mul_arbiter: directed bench for dsum_mul_arbiter with a behavioural two-stage multiplier
module tb_dsum_mul_arbiter;
  localparam int N = 4, ID_W = 2, A_W = 63, B_W = 11, P_W = 73;
  logic clk = 0;
  logic reset = 0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*A_W-1:0] req_a = '0;
  logic [N*B_W-1:0] req_b = '0;
  logic mul_ce;
  logic [A_W-1:0] mul_din0;
  logic [B_W-1:0] mul_din1;
  logic [P_W-1:0] mul_dout;
  logic res_valid;
  logic res_ready = 1;
  logic [ID_W-1:0] res_id;
  logic [P_W-1:0] res_data;
`ifdef DSUM_MUL_ARB_STATS_EN
  logic [31:0] stat_issued, stat_stall;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  dsum_mul_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
`ifdef DSUM_MUL_ARB_STATS_EN
    .stat_issued(stat_issued), .stat_stall(stat_stall),
`endif
    .res_data(res_data)
  );
  logic [A_W-1:0] m_a = '0;
  logic [B_W-1:0] m_b = '0;
  logic [P_W-1:0] m_p = '0;
  always @(posedge clk) if (mul_ce) begin
    m_a <= mul_din0;
    m_b <= mul_din1;
    m_p <= $signed({{10{m_a[A_W-1]}}, m_a}) * $signed({{62{m_b[B_W-1]}}, m_b});
  end
  assign mul_dout = m_p;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_p(input string tag, input logic [P_W-1:0] obs, input logic [P_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic setop(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    req_a[i*A_W +: A_W] = a;
    req_b[i*B_W +: B_W] = b;
  endtask
  task automatic do_reset;
    reset = 0;
    req_valid = '0;
    res_ready = 1;
    tick;
    tick;
    @(negedge clk) reset = 1;
    tick;
  endtask
  initial begin
    tick;
    chk("rst_valid", res_valid, 0);
    chk("rst_id", res_id, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_ce", mul_ce, 1);
    @(negedge clk) reset = 1;
    tick;
    // single requester, -3 x 5
    setop(1, -3, 5);
    req_valid = 4'b0010;
    #1;
    chk("t1_ready", req_ready, 4'b0010);
    chk("t1_din0", mul_din0, 63'h7FFF_FFFF_FFFF_FFFD);
    chk("t1_din1", mul_din1, 11'd5);
    tick;
    req_valid = '0;
    chk("t1_lat", res_valid, 0);
    tick;
    chk("t1_valid", res_valid, 1);
    chk_p("t1_data", res_data, -15);
    chk("t1_id", res_id, 1);
    tick;
    chk("t1_once", res_valid, 0);
    // all four requesters continuously
    do_reset;
    for (int i = 0; i < N; i++) setop(i, i + 1, 10);
    for (int c = 0; c < 8; c++) begin
      req_valid = (c < 6) ? 4'hF : 4'h0;
      #1;
      if (c < 6) chk("rr_ready", req_ready, 4'b0001 << (c % 4));
      if (c >= 2) begin
        chk("rr_valid", res_valid, 1);
        chk("rr_id", res_id, (c - 2) % 4);
        chk_p("rr_data", res_data, 10 * ((c - 2) % 4 + 1));
      end
      tick;
    end
    // three back-to-back issues then a five-cycle stall
    do_reset;
    for (int k = 0; k < 3; k++) begin
      setop(3, 100 * (k + 1), k + 1);
      req_valid = 4'b1000;
      #1;
      chk("st_ready", req_ready, 4'b1000);
      if (k == 2) chk_p("st_first", res_data, 100);
      tick;
    end
    setop(0, 7, 7);
    req_valid = 4'b0001;
    res_ready = 0;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("st_ce", mul_ce, 0);
      chk("st_noready", req_ready, 0);
      chk("st_valid", res_valid, 1);
      chk("st_id", res_id, 3);
      chk_p("st_data", res_data, 400);
      tick;
    end
    res_ready = 1;
    req_valid = '0;
    #1;
`ifdef DSUM_MUL_ARB_STATS_EN
    chk("st_stat_stall", stat_stall, 5);
    chk("st_stat_issued", stat_issued, 3);
`endif
    chk_p("st_rel1", res_data, 400);
    tick;
    chk("st_rel2_v", res_valid, 1);
    chk_p("st_rel2", res_data, 900);
    tick;
    chk("st_empty", res_valid, 0);
    // extreme operands
    setop(0, 63'h3FFF_FFFF_FFFF_FFFF, 11'h400);
    req_valid = 4'b0001;
    #1;
    chk("mx_ready", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    tick;
    chk("mx_valid", res_valid, 1);
    chk_p("mx_data", res_data, 73'h1000000000000000400);
    chk("mx_id", res_id, 0);
    // asynchronous reset with two operations in flight
    setop(1, 11, 1);
    req_valid = 4'b0010;
    tick;
    setop(1, 12, 1);
    tick;
    req_valid = '0;
    chk("ar_pre", res_valid, 1);
    #1 reset = 0;
    #1;
    chk("ar_valid", res_valid, 0);
    chk("ar_id", res_id, 0);
    tick;
    @(negedge clk) reset = 1;
    setop(2, 6, -2);
    req_valid = 4'b0100;
    #1;
    chk("ar_ready", req_ready, 4'b0100);
    tick;
    req_valid = '0;
    tick;
    chk("ar_res_v", res_valid, 1);
    chk("ar_res_id", res_id, 2);
    chk_p("ar_res_d", res_data, -12);
    // pointer at 1 with requesters 0 and 3, then a gap cycle
    setop(0, 1, 1);
    req_valid = 4'b0001;
    #1;
    chk("pt_set", req_ready, 4'b0001);
    tick;
    setop(3, 2, 1);
    req_valid = 4'b1001;
    #1;
    chk("pt_first3", req_ready, 4'b1000);
    tick;
    req_valid = 4'b0001;
    #1;
    chk("pt_then0", req_ready, 4'b0001);
    chk("pt_id0", res_id, 0);
    tick;
    req_valid = '0;
    #1;
    chk("pt_gap", req_ready, 0);
    chk("pt_id3", res_id, 3);
    tick;
    req_valid = 4'b1001;
    #1;
    chk("pt_hold", req_ready, 4'b1000);
    tick;
    req_valid = '0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dsum_mul_arbiter.md
Name: dsum_mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares one pipelined signed multiplier (63s x 11s -> 73, registered inputs plus registered product, gated by ce) among N_REQ delay-and-sum channel requesters. It issues at most one operand pair per cycle and drives the multiplier ce. It carries a requester tag through a shadow pipeline so each product returns with its owner id. A single result port with valid/ready backpressure stalls the whole multiplier pipeline.

Parameters:
N_REQ, 4, number of requesters (2..16)
ID_W, 2, tag width, must satisfy 2**ID_W >= N_REQ
A_W, 63, signed operand A width (din0)
B_W, 11, signed operand B width (din1)
P_W, 73, signed product width (dout)
MUL_LAT, 2, multiplier latency in ce-enabled cycles (din registered, then buff0)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
req_valid  in  N_REQ  per-requester operand valid
req_ready  out  N_REQ  per-requester accept, one-hot or zero
req_a  in  N_REQ*A_W  packed signed A operands, requester i at [i*A_W +: A_W]
req_b  in  N_REQ*B_W  packed signed B operands
mul_ce  out  1  multiplier clock enable
mul_din0  out  A_W  to multiplier din0
mul_din1  out  B_W  to multiplier din1
mul_dout  in  P_W  from multiplier dout
res_valid  out  1  product valid
res_ready  in  1  downstream accept
res_id  out  ID_W  requester index that owns res_data
res_data  out  P_W  signed product, equal to mul_dout

Behaviour:
- Shadow pipeline: vld[0..MUL_LAT-1] and tag[0..MUL_LAT-1] registers, advanced only when mul_ce=1.
- res_valid = vld[MUL_LAT-1]; res_id = tag[MUL_LAT-1]; res_data = mul_dout (combinational pass-through).
- mul_ce = !res_valid | res_ready. The pipeline stalls only when a held result is refused, and bubbles never block.
- Grant: combinational round-robin starting at pointer ptr. g = first i in ptr, ptr+1, ... (mod N_REQ) with req_valid[i]=1.
- req_ready[g] = mul_ce & |req_valid; all other bits 0. No ready is raised while stalled.
- Issue occurs when mul_ce & |req_valid:
  - mul_din0 = req_a[g], mul_din1 = req_b[g];
  - vld[0] <= 1, tag[0] <= g;
  - ptr <= (g+1) mod N_REQ.
- With mul_ce=1 and no request: vld[0] <= 0 and ptr holds. mul_din0/din1 carry requester ptr's operands, which are don't-care.
- Transfer on req_valid[i] & req_ready[i]. A requester must hold valid and operands stable until accepted.
- Result consumed on res_valid & res_ready.
- Latency: operand accepted at edge k gives res_valid at edge k+MUL_LAT with no stall. Throughput is 1 per cycle.
- Stall: while res_valid & !res_ready, all of the following hold: mul_ce=0, ptr frozen, vld/tag frozen, res_data stable (multiplier buff0 is gated by ce).
- Simultaneous events: a result can be accepted and a new issue made in the same cycle.
- Reset (reset=0, asynchronous) clears vld=0, tag=0, ptr=0, so res_valid=0, res_id=0, req_ready=0.
  - Mid-operation reset discards in-flight products. Multiplier registers are not cleared, but because vld=0 no stale data is ever presented.
  - Deassertion is synchronized externally. The first grant can occur on the first edge after release.
- Widths: no truncation or rounding. Signed operands are passed unchanged, and P_W = A_W + B_W - 1 is the caller's contract. The (-2^(A_W-1)) x (-2^(B_W-1)) case is excluded upstream.

Optional Feature:
Macro DSUM_MUL_ARB_STATS_EN.
- Defined: extra outputs stat_issued[31:0] (increments on each issue) and stat_stall[31:0] (increments each cycle with mul_ce=0). Both wrap at 2^32-1 -> 0 and clear on reset.
- Undefined: ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Requester 1 alone, a=-3, b=5, res_ready=1 -> res_valid exactly 2 cycles after accept, res_data=-15, res_id=1.
- All 4 requesters valid continuously, res_ready=1 -> grant order 0,1,2,3,0,1...; res_id follows the same order 2 cycles later; one result per cycle.
- Issue 3 ops back-to-back, then hold res_ready=0 for 5 cycles -> mul_ce=0, req_ready=0, res_data/res_id frozen; release -> results delivered in order with no loss or duplication. With the macro defined, stat_stall=5.
- a=2^62-1, b=-1024 -> res_data = -(2^72-1024), sign-correct in all 73 bits.
- reset=0 asynchronously with 2 ops in flight -> res_valid=0 immediately (before the next edge); after release the first request (req 2) gets res_id=2 with ptr restarted at 0.
- Requesters 0 and 3 valid, ptr=1 -> req 3 granted first, then req 0; a gap cycle with no requests leaves ptr unchanged.
